// File: rtl/vga_clken_gen.sv
// Multi-channel phase-accumulator clock-enable generator. A small FSM tracks
// config writes and reports `locked` once the running channels have settled.
module vga_clken_gen #(
  parameter int NUM_CH        = 2,
  parameter int ACC_W         = 16,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic [NUM_CH-1:0] clken,
  output logic              locked
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LOCKED
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [7:0]       cnt;
  logic [7:0]       cnt_next;
  logic [ACC_W-1:0] inc [NUM_CH];
  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W:0]   sum [NUM_CH];
  logic [NUM_CH-1:0] active;
  logic             accept;
  logic             wr_hit;
  logic             any_active;

  assign cfg_ready  = !rst && (state != SETTLE);
  assign accept     = cfg_valid && cfg_ready;
  // Writes to a channel that does not exist still handshake but touch nothing.
  assign wr_hit     = accept && (int'(cfg_ch) < NUM_CH);
  assign any_active = |active;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i]    = {1'b0, acc[i]} + {1'b0, inc[i]};
      active[i] = ch_enable[i] && (inc[i] != '0);
    end
  end

  // The carry out of each accumulator add becomes that channel's enable pulse.
  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        inc[i] <= '0;
        acc[i] <= '0;
      end
      clken <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_hit && (int'(cfg_ch) == i)) begin
          inc[i]   <= cfg_inc;
          acc[i]   <= cfg_phase;
          clken[i] <= 1'b0;
        end else if (ch_enable[i]) begin
          acc[i]   <= sum[i][ACC_W-1:0];
          clken[i] <= sum[i][ACC_W];
        end else begin
          clken[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (wr_hit) begin
          state_next = SETTLE;
          cnt_next   = 8'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (cnt == 8'd0) begin
          state_next = any_active ? LOCKED : IDLE;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      LOCKED: begin
        if (wr_hit) begin
          state_next = SETTLE;
          cnt_next   = 8'(SETTLE_CYCLES - 1);
        end else if (!any_active) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // locked trails the LOCKED state by one cycle but drops at once on a new write.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      locked <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      locked <= (state == LOCKED) && !wr_hit;
    end
  end

endmodule

// File: tb/tb_vga_clken_gen.sv
// Self-checking bench for vga_clken_gen: a reference model feeds a scoreboard
// for the default-size instance, plus directed checks on a 4-bit instance.
module tb_vga_clken_gen;

  localparam int NUM_CH  = 2;
  localparam int ACC_W   = 16;
  localparam int SETTLE  = 16;
  localparam int S_ACC_W = 4;
  localparam int S_SETTLE = 4;

  logic              refclk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic [ACC_W-1:0]  cfg_phase;
  logic [NUM_CH-1:0] ch_enable;
  logic [NUM_CH-1:0] clken;
  logic              locked;

  logic               s_rst;
  logic               s_cfg_valid;
  logic               s_cfg_ready;
  logic [1:0]         s_cfg_ch;
  logic [S_ACC_W-1:0] s_cfg_inc;
  logic [S_ACC_W-1:0] s_cfg_phase;
  logic [NUM_CH-1:0]  s_ch_enable;
  logic [NUM_CH-1:0]  s_clken;
  logic               s_locked;

  vga_clken_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .SETTLE_CYCLES(SETTLE)) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_phase(cfg_phase),
    .ch_enable(ch_enable), .clken(clken), .locked(locked)
  );

  vga_clken_gen #(.NUM_CH(NUM_CH), .ACC_W(S_ACC_W), .SETTLE_CYCLES(S_SETTLE)) dut_s (
    .refclk(refclk), .rst(s_rst), .cfg_valid(s_cfg_valid), .cfg_ready(s_cfg_ready),
    .cfg_ch(s_cfg_ch), .cfg_inc(s_cfg_inc), .cfg_phase(s_cfg_phase),
    .ch_enable(s_ch_enable), .clken(s_clken), .locked(s_locked)
  );

  always #5 refclk = ~refclk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string             tag;
    logic [NUM_CH-1:0] clken;
    logic              locked;
  } exp_t;

  exp_t sb[$];

  typedef enum {M_IDLE, M_SETTLE, M_LOCKED} mstate_t;
  mstate_t m_state = M_IDLE;
  int      m_cnt   = 0;
  longint  m_inc [NUM_CH];
  longint  m_acc [NUM_CH];
  bit      check_en = 1'b1;

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Predicts the result of the coming edge for the large instance, queues it,
  // clocks once and compares what the DUT produced.
  task automatic applyStimulus(string tag);
    exp_t   e;
    exp_t   got;
    bit     ready_exp;
    bit     wr;
    bit     any;
    longint wrap;
    wrap = longint'(1) << ACC_W;
    #1;
    ready_exp = !rst && (m_state != M_SETTLE);
    if (check_en) checkOutput({tag, "/ready"}, 32'(cfg_ready), 32'(ready_exp));
    wr  = cfg_valid && ready_exp && (int'(cfg_ch) < NUM_CH);
    any = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_enable[i] && m_inc[i] != 0) any = 1'b1;
    e.tag    = tag;
    e.clken  = '0;
    e.locked = 1'b0;
    if (rst) begin
      m_state = M_IDLE;
      m_cnt   = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_inc[i] = 0;
        m_acc[i] = 0;
      end
    end else begin
      e.locked = (m_state == M_LOCKED) && !wr;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr && int'(cfg_ch) == i) begin
          m_inc[i] = longint'(cfg_inc);
          m_acc[i] = longint'(cfg_phase);
        end else if (ch_enable[i]) begin
          m_acc[i] = m_acc[i] + m_inc[i];
          if (m_acc[i] >= wrap) begin
            e.clken[i] = 1'b1;
            m_acc[i]   = m_acc[i] - wrap;
          end
        end
      end
      if (wr) begin
        m_state = M_SETTLE;
        m_cnt   = SETTLE - 1;
      end else if (m_state == M_SETTLE) begin
        if (m_cnt == 0) m_state = any ? M_LOCKED : M_IDLE;
        else m_cnt--;
      end else if (m_state == M_LOCKED && !any) begin
        m_state = M_IDLE;
      end
    end
    if (check_en) sb.push_back(e);
    @(posedge refclk);
    #1;
    if (check_en) begin
      if (sb.size() == 0) begin
        checkOutput({tag, "/scoreboard_empty"}, 32'd0, 32'd1);
      end else begin
        got = sb.pop_front();
        checkOutput({got.tag, "/clken"}, 32'(clken), 32'(got.clken));
        checkOutput({got.tag, "/locked"}, 32'(locked), 32'(got.locked));
      end
    end
  endtask

  task automatic stepS();
    @(posedge refclk);
    #1;
  endtask

  initial begin
    int n;
    int low;
    int pulses;

    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_inc = '0; cfg_phase = '0; ch_enable = '0;
    s_rst = 1'b1; s_cfg_valid = 1'b0; s_cfg_ch = 2'd0; s_cfg_inc = '0; s_cfg_phase = '0;
    s_ch_enable = '0;

    // 4-bit instance: reset values, then inc=4 pulses every 4th cycle
    repeat (2) stepS();
    checkOutput("s_reset/clken", 32'(s_clken), 32'd0);
    checkOutput("s_reset/locked", 32'(s_locked), 32'd0);
    checkOutput("s_reset/ready", 32'(s_cfg_ready), 32'd0);
    s_rst = 1'b0; s_ch_enable = 2'b01;
    s_cfg_valid = 1'b1; s_cfg_ch = 2'd0; s_cfg_inc = 4'd4; s_cfg_phase = 4'd0;
    #1;
    checkOutput("s_idle/ready", 32'(s_cfg_ready), 32'd1);
    stepS();
    s_cfg_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      stepS();
      checkOutput($sformatf("s_inc4/clken_k%0d", k), 32'(s_clken[0]), 32'((k % 4) == 0));
      checkOutput($sformatf("s_inc4/locked_k%0d", k), 32'(s_locked), 32'(k >= S_SETTLE + 1));
    end

    // 4-bit instance: max increment misses exactly one pulse per wrap
    s_cfg_valid = 1'b1; s_cfg_inc = 4'd15; s_cfg_phase = 4'd0;
    #1;
    checkOutput("s_locked/ready", 32'(s_cfg_ready), 32'd1);
    stepS();
    s_cfg_valid = 1'b0;
    checkOutput("s_rewrite/locked_drop", 32'(s_locked), 32'd0);
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      stepS();
      checkOutput($sformatf("s_inc15/clken_k%0d", k), 32'(s_clken[0]), 32'(k != 1));
      if (s_clken[0]) pulses++;
    end
    checkOutput("s_inc15/pulse_count", 32'(pulses), 32'd15);

    // 16-bit instance: reset wins over a simultaneous write
    ch_enable = 2'b11; cfg_valid = 1'b1; cfg_inc = 16'd77;
    applyStimulus("reset");
    applyStimulus("reset");
    rst = 1'b0; cfg_valid = 1'b0;
    repeat (3) applyStimulus("idle_inc0");

    // settling with no running channel falls back to IDLE
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'd0; cfg_phase = 16'h1234;
    applyStimulus("wr_inc0");
    cfg_valid = 1'b0;
    repeat (SETTLE + 3) applyStimulus("settle_inc0");

    // lock on ch0 at a quarter of refclk
    ch_enable = 2'b01;
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'h4000; cfg_phase = 16'd0;
    applyStimulus("wr_ch0");
    cfg_valid = 1'b0;
    n = 0;
    do begin
      applyStimulus("lock_ch0");
      n++;
    end while (locked !== 1'b1 && n < 40);
    checkOutput("lock_ch0/latency", 32'(n), 32'(SETTLE + 1));
    repeat (8) applyStimulus("run_ch0");

    // rewrite ch1 while locked
    ch_enable = 2'b11;
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_inc = 16'd1000; cfg_phase = 16'd5;
    applyStimulus("wr_ch1_locked");
    cfg_valid = 1'b0;
    checkOutput("relock/locked_drop", 32'(locked), 32'd0);
    low = 0;
    for (int k = 0; k < 20; k++) begin
      if (!cfg_ready) low++;
      applyStimulus("relock");
    end
    checkOutput("relock/ready_low_cycles", 32'(low), 32'(SETTLE));
    checkOutput("relock/locked_again", 32'(locked), 32'd1);

    // out-of-range channel: handshake only
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_inc = 16'hFFFF; cfg_phase = 16'hAAAA;
    applyStimulus("wr_bad_ch3");
    cfg_ch = 2'd2;
    applyStimulus("wr_bad_ch2");
    cfg_valid = 1'b0;
    checkOutput("bad_ch/locked_kept", 32'(locked), 32'd1);
    checkOutput("bad_ch/ready_kept", 32'(cfg_ready), 32'd1);
    repeat (6) applyStimulus("after_bad_ch");

    // drop all enables, then resume from the held phase
    ch_enable = 2'b00;
    applyStimulus("drop_en");
    checkOutput("drop_en/clken_now", 32'(clken), 32'd0);
    applyStimulus("drop_en_next");
    checkOutput("drop_en/locked_low", 32'(locked), 32'd0);
    repeat (3) applyStimulus("held");
    ch_enable = 2'b11;
    repeat (12) applyStimulus("resume");

    // max increment on ch1
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_inc = 16'hFFFF; cfg_phase = 16'd0;
    applyStimulus("wr_ch1_max");
    cfg_valid = 1'b0;
    repeat (20) applyStimulus("run_ch1_max");

    // reset in the middle of settling, with a write presented
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'h2000; cfg_phase = 16'd0;
    applyStimulus("wr_pre_rst");
    cfg_valid = 1'b0;
    repeat (3) applyStimulus("settle_pre_rst");
    rst = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'd999;
    applyStimulus("rst_mid_settle");
    rst = 1'b0; cfg_valid = 1'b0;
    checkOutput("rst_mid/clken", 32'(clken), 32'd0);
    checkOutput("rst_mid/locked", 32'(locked), 32'd0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus("post_rst");
      if (clken != '0) pulses++;
    end
    checkOutput("rst_mid/write_discarded", 32'(pulses), 32'd0);

    // 50 -> 27 MHz ratio over a full accumulator period
    ch_enable = 2'b01;
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_inc = 16'd35389; cfg_phase = 16'd0;
    applyStimulus("wr_27mhz");
    cfg_valid = 1'b0;
    check_en = 1'b0;
    pulses = 0;
    for (int k = 0; k < 65536; k++) begin
      applyStimulus("run_27mhz");
      if (clken[0]) pulses++;
    end
    check_en = 1'b1;
    checkOutput("27mhz/pulse_count", 32'(pulses), 32'd35389);
    applyStimulus("after_27mhz");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
